// File: rtl/demux4b_1_to_2.sv
// demux4b_1_to_2: steers 4-bit words from one valid/ready input stream to
// one of two output streams. Each output owns an independent 2-entry FIFO.
//
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   in_data[3:0]             word to steer
//   in_sel                   destination (0 = port 0, 1 = port 1)
//   in_valid / in_ready      input handshake; in_ready = !full of selected FIFO
//   outN_data[3:0]           head word of FIFO N (0 when empty)
//   outN_valid / outN_ready  output handshake for FIFO N
//   outN_cnt[7:0]            saturating delivered-word counter for port N
//
// Configuration macro: DEMUX4B_XFER_CNT_EN
//   defined   -> outN_cnt counts pops on port N, saturating at 8'hFF
//   undefined -> no counter registers; outN_cnt tied to 8'h00
module demux4b_1_to_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out0_data,
  output logic       out0_valid,
  input  logic       out0_ready,
  output logic [7:0] out0_cnt,
  output logic [3:0] out1_data,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [7:0] out1_cnt
);

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] out_ready;
  logic [1:0] pop;
  logic [3:0] head [2];

  assign out_ready = {out1_ready, out0_ready};

  // Ready depends only on the selected FIFO's fullness, never on the
  // consumer side, so a pop in the same cycle cannot free a full FIFO.
  assign in_ready = !full[in_sel];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [3:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;
    logic       push;

    assign push     = in_valid && in_ready && (in_sel == 1'(g));
    assign valid[g] = (occ != 2'd0);
    assign full[g]  = (occ == 2'd2);
    assign pop[g]   = valid[g] && out_ready[g];
    assign head[g]  = valid[g] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        occ    <= 2'd0;
      end else begin
        if (push) wr_ptr <= !wr_ptr;
        if (pop[g]) rd_ptr <= !rd_ptr;
        case ({push, pop[g]})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end

    // Storage needs no reset: contents are only visible while occ != 0.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];

`ifdef DEMUX4B_XFER_CNT_EN
  logic [7:0] cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (pop[p] && (cnt[p] != '1)) cnt[p] <= cnt[p] + 8'd1;
      end
    end
  end

  assign out0_cnt = cnt[0];
  assign out1_cnt = cnt[1];
`else
  assign out0_cnt = '0;
  assign out1_cnt = '0;
`endif

endmodule

// File: tb/tb_demux4b_1_to_2.sv
module tb_demux4b_1_to_2;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_cnt;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  demux4b_1_to_2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_cnt   (out0_cnt),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_cnt   (out1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DEMUX4B_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Behavioural model: two queues of words plus delivered-word tallies.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      bit do_pop0, do_pop1, do_push;
      do_pop0 = (q0.size() > 0) && out0_ready;
      do_pop1 = (q1.size() > 0) && out1_ready;
      do_push = in_valid && ((in_sel ? q1.size() : q0.size()) < 2);
      if (do_pop0) begin
        void'(q0.pop_front());
        if (m_cnt0 < 255) m_cnt0++;
      end
      if (do_pop1) begin
        void'(q1.pop_front());
        if (m_cnt1 < 255) m_cnt1++;
      end
      if (do_push) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model out0_valid", int'(out0_valid), int'(q0.size() > 0));
      check("model out1_valid", int'(out1_valid), int'(q1.size() > 0));
      check("model out0_data", int'(out0_data), (q0.size() > 0) ? int'(q0[0]) : 0);
      check("model out1_data", int'(out1_data), (q1.size() > 0) ? int'(q1[0]) : 0);
      check("model in_ready", int'(in_ready), int'((in_sel ? q1.size() : q0.size()) < 2));
      check("model out0_cnt", int'(out0_cnt), CNT_EN ? m_cnt0 : 0);
      check("model out1_cnt", int'(out1_cnt), CNT_EN ? m_cnt1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out0_valid"}, int'(out0_valid), 0);
    check({tag, " out1_valid"}, int'(out1_valid), 0);
    check({tag, " out0_data"}, int'(out0_data), 0);
    check({tag, " out1_data"}, int'(out1_data), 0);
    check({tag, " out0_cnt"}, int'(out0_cnt), 0);
    check({tag, " out1_cnt"}, int'(out1_cnt), 0);
    check({tag, " in_ready"}, int'(in_ready), 1);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    #3;
    do_reset();

    // Basic steering
    drive(1'b1, 1'b0, 4'hA);
    tick(); #1;
    check("steer out0_valid", int'(out0_valid), 1);
    check("steer out0_data", int'(out0_data), 'hA);
    drive(1'b1, 1'b1, 4'h5);
    tick(); #1;
    check("steer out0_valid one cycle", int'(out0_valid), 0);
    check("steer out1_valid", int'(out1_valid), 1);
    check("steer out1_data", int'(out1_data), 'h5);
    drive(1'b0, 1'b0, 4'h0);
    tick(); #1;
    check("steer out1_valid one cycle", int'(out1_valid), 0);

    // Full and backpressure on port 0
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h1);
    tick();
    drive(1'b1, 1'b0, 4'h2);
    tick(); #1;
    check("full in_ready", int'(in_ready), 0);
    drive(1'b1, 1'b0, 4'h3);
    tick(); #1;
    check("full head held", int'(out0_data), 'h1);
    check("full in_ready held", int'(in_ready), 0);
    out0_ready = 1'b1;
    tick(); #1;
    check("bp second word", int'(out0_data), 'h2);
    check("bp in_ready reopens", int'(in_ready), 1);
    tick(); #1;
    check("bp third word", int'(out0_data), 'h3);
    drive(1'b0, 1'b0, 4'h0);
    tick(); #1;
    check("bp drained", int'(out0_valid), 0);

    // Independence of the two FIFOs
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h8);
    tick();
    drive(1'b1, 1'b0, 4'h9);
    tick();
    drive(1'b1, 1'b0, 4'hC);
    #1;
    check("indep sel0 in_ready", int'(in_ready), 0);
    in_sel = 1'b1;
    #1;
    check("indep sel1 in_ready", int'(in_ready), 1);
    tick(); #1;
    check("indep out1_data", int'(out1_data), 'hC);
    check("indep out0 untouched", int'(out0_data), 'h8);

    // Simultaneous push/pop at occupancy 1 on port 1
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 4'h7);
    tick(); #1;
    check("pushpop out1_valid", int'(out1_valid), 1);
    check("pushpop out1_data", int'(out1_data), 'h7);
    drive(1'b0, 1'b0, 4'h0);
    tick(); #1;
    check("pushpop occupancy 1", int'(out1_valid), 0);

    // Reset mid-operation with both FIFOs full (port 0 already holds 8,9)
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 4'hD);
    tick();
    drive(1'b1, 1'b1, 4'hE);
    tick(); #1;
    check("prefill out0_valid", int'(out0_valid), 1);
    check("prefill out1_data", int'(out1_data), 'hD);
    do_reset();

    // Directed mixed traffic table
    for (int i = 0; i < 48; i++) begin
      drive(1'(i % 3 != 2), 1'((i / 2) % 2), 4'(i));
      out0_ready = 1'((i % 5) != 1);
      out1_ready = 1'((i % 4) == 0);
      tick();
    end

    // Counter saturation on port 0
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 4'h6);
    repeat (302) tick();
    drive(1'b0, 1'b0, 4'h0);
    tick(); #1;
    check("cnt out0_cnt", int'(out0_cnt), CNT_EN ? 'hFF : 'h00);
    check("cnt out1_cnt", int'(out1_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux4b_1_to_2.md
DEMUX4B_1_TO_2 -- requirements
Module: demux4b_1_to_2

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_data, input, 4 bits: word to be steered.
REQ-004 The block SHALL have port in_sel, input, 1 bit: destination, 0 = port 0, 1 = port 1; qualified by in_valid.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data/in_sel valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the destination selected by in_sel can accept.
REQ-007 The block SHALL have ports out0_data / out1_data, output, 4 bits each: head word of each destination queue.
REQ-008 The block SHALL have ports out0_valid / out1_valid, output, 1 bit each: the destination queue is non-empty.
REQ-009 The block SHALL have ports out0_ready / out1_ready, input, 1 bit each: the consumer takes the head word.
REQ-010 The block SHALL have ports out0_cnt / out1_cnt, output, 8 bits each: delivered-word counters (see Configuration).

Function
REQ-011 Each destination SHALL own an independent 2-entry FIFO, with pointers and a 2-bit occupancy of 0..2.
REQ-012 in_ready SHALL be combinational: !full of the FIFO selected by the current in_sel; it SHALL NOT depend on outN_ready (no pass-through when full).
REQ-013 A push SHALL occur on a rising edge with in_valid && in_ready, writing in_data to the FIFO selected by in_sel; the other FIFO SHALL be untouched.
REQ-014 A pop on port N SHALL occur on a rising edge with outN_valid && outN_ready.
REQ-015 Latency SHALL be one cycle: a word pushed at edge k SHALL be visible on outN_data with outN_valid=1 after edge k, if the FIFO was empty.
REQ-016 Per-port order SHALL be preserved (FIFO); there is no ordering guarantee between ports.
REQ-017 When outN_valid=0, outN_data SHALL be 4'h0.
REQ-018 A simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged.
- Applies at occupancy 1.
- Applies at occupancy 2 only if in_ready was already 1, which cannot happen; push is refused when full even if a pop occurs that cycle.
REQ-019 Pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 or underflow below 0.
REQ-020 outN_ready asserted while the FIFO is empty SHALL have no effect.
REQ-021 in_sel changing while in_valid=1 and in_ready=0 SHALL be permitted; in_ready SHALL follow the new selection in the same cycle.

Reset
REQ-022 While rst_n=0, both FIFOs SHALL be empty, pointers 0, and out0_valid, out1_valid, out0_data, out1_data, out0_cnt and out1_cnt SHALL all be 0.
REQ-023 in_ready SHALL read 1 during and after reset.
REQ-024 Reset asserted mid-operation SHALL discard all buffered words immediately and asynchronously.
REQ-025 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DEMUX4B_XFER_CNT_EN defined: outN_cnt SHALL increment by 1 on every pop of port N and SHALL saturate at 8'hFF.
REQ-027 Macro DEMUX4B_XFER_CNT_EN undefined: the counter registers SHALL NOT exist, and out0_cnt/out1_cnt SHALL be tied to 8'h00.

Verification
REQ-028 Basic steering: after reset, push 4'hA with sel=0, then 4'h5 with sel=1, with both readys held 1 -> out0 presents A one cycle after its push, out1 presents 5 one cycle after its push; each valid is high for exactly one cycle.
REQ-029 Full and backpressure: with out0_ready=0, push 1, 2, 3 with sel=0 -> 1 and 2 are accepted, in_ready drops to 0 after the second push, and 3 is held; set out0_ready=1 -> out0 delivers 1 then 2, 3 is accepted and then delivered, preserving order 1, 2, 3.
REQ-030 Independence: port 0 full with in_valid=1 and sel=0 -> in_ready=0; switch sel=1 in the same cycle -> in_ready=1 and the word lands only in port 1.
REQ-031 Simultaneous push/pop: occupancy 1 on port 1, push 4'h7 and pop in the same cycle -> occupancy stays 1 and out1_data=7 on the next cycle.
REQ-032 Reset mid-operation: both FIFOs hold 2 words, assert rst_n=0 asynchronously -> all valids, data and counts read 0 immediately, and in_ready=1.
REQ-033 Counter: with DEMUX4B_XFER_CNT_EN defined, 300 pops on port 0 -> out0_cnt=8'hFF and out1_cnt=0; with the macro undefined -> out0_cnt=8'h00 throughout.
